aesl_axis_stall_sensor: RTL
===========================

// Module: aesl_axis_stall_sensor
// PURPOSE
//  Produces the per-channel axis_block_sigs vector that the deadlock monitors consume in C/RTL cosim.
//  Watches the tvalid/tready pair of each AXI-Stream port on the DUT boundary.
//  Flags a channel as blocked once it has stalled for THRESHOLD consecutive cycles.
//  Also latches which channel blocked first, for the deadlock report.
// PARAMETERS
//  N_CH       4        number of AXI-Stream channels monitored (1..32)
//  DIR_MASK   4'b0011  per-channel role: 1 = DUT reads (sink), 0 = DUT writes (source)
//  THRESHOLD  16       consecutive stalled cycles before block asserts (>=1)
//  CNT_W      5        counter width; must satisfy 2**CNT_W > THRESHOLD
//  IDX_W      2        width of channel index; must satisfy 2**IDX_W >= N_CH
// PORTS
//  clock            in   1      single clock, all state on posedge
//  reset            in   1      synchronous, active-high
//  enable           in   1      1 = monitoring active; 0 = counting suspended and counters cleared
//  clear            in   1      synchronous soft clear of all state (same effect as reset)
//  tvalid           in   N_CH   tvalid of each monitored stream
//  tready           in   N_CH   tready of each monitored stream
//  axis_block_sigs  out  N_CH   registered per-channel blocked flag
//  block_any        out  1      OR of axis_block_sigs (combinational from registers)
//  first_vld        out  1      sticky: some channel has blocked since reset/clear
//  first_idx        out  IDX_W  index of the first channel to block (valid when first_vld=1)
// BEHAVIOUR
//  Reset values
//   - reset/clear: all channels go to IDLE with cnt=0.
//   - Outputs after reset/clear: axis_block_sigs=0, first_vld=0, first_idx=0.
//   - clear has priority over every other input.
//  Stall condition per channel i
//   - stall[i] = DIR_MASK[i] ? (tready & ~tvalid) : (tvalid & ~tready).
//   - A transfer (tvalid & tready) is never a stall.
//   - Both low is never a stall.
//  Per-channel FSM: IDLE -> COUNT -> BLOCKED
//   - IDLE: enable & stall -> cnt=1. If THRESHOLD==1 go to BLOCKED, else go to COUNT.
//   - COUNT: enable & stall -> cnt++. Go to BLOCKED on the edge where cnt reaches THRESHOLD.
//   - COUNT: ~stall or ~enable -> IDLE, cnt=0.
//   - BLOCKED: axis_block_sigs[i]=1; cnt holds at THRESHOLD (saturates, never wraps).
//   - BLOCKED: ~stall or ~enable -> IDLE, cnt=0, flag drops on that same edge.
//   - axis_block_sigs[i] = (state==BLOCKED), registered.
//  Latency
//   - stall sampled high on edges e1..eT (T=THRESHOLD) -> flag is 1 after edge eT.
//   - First sample without stall -> flag is 0 after that edge.
//  Stall runs
//   - Any gap of one non-stall cycle restarts the count from zero.
//  First-block capture
//   - On the first edge where any channel enters BLOCKED while first_vld=0: first_vld<=1, first_idx<=that channel.
//   - Simultaneous entries: the lowest index wins.
//   - first_vld/first_idx are sticky until reset or clear, even after the channels unblock.
//  Widths
//   - Channels are fully independent; no cross-channel arithmetic.
//   - cnt is unsigned CNT_W bits.
//  Mid-operation reset/clear
//   - Takes effect on the next edge regardless of state.
//   - A stall that persists through it restarts counting from 1 on the first edge after reset/clear deasserts.
// TESTING
//  1. THRESHOLD=16, ch0 sink, tready=1 & tvalid=0 held: axis_block_sigs[0]=0 after edge 15, =1 after edge 16; first_vld=1, first_idx=0.
//  2. ch2 source, tvalid=1 & tready=0 for 15 cycles, then 1 cycle tready=1, then 16 stall cycles: flag stays 0 through cycle 16, rises after the 16th new stall.
//  3. ch1 and ch3 start stalling on the same cycle: both flags rise on the same edge; first_idx=1.
//  4. ch0 blocked, then tvalid=1 for one cycle: flag 0 after that edge; first_vld stays 1, first_idx stays 0.
//  5. ch0 blocked, pulse clear 1 cycle with the stall held: all outputs 0 after the clear edge; flag re-asserts 16 edges later.
//  6. enable=0 with ch0 stalled for 40 cycles: flag stays 0; enable=1 -> flag rises after 16 edges.

Source files
------------

// File: rtl/aesl_axis_stall_sensor.sv
// Per-channel AXI-Stream stall detector. A channel is flagged blocked after THRESHOLD
// consecutive stalled cycles, and the first channel ever to block is latched for reporting.
module aesl_axis_stall_sensor #(
  parameter int              N_CH      = 4,
  parameter logic [N_CH-1:0] DIR_MASK  = N_CH'(4'b0011),
  parameter int              THRESHOLD = 16,
  parameter int              CNT_W     = 5,
  parameter int              IDX_W     = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [N_CH-1:0]  tvalid,
  input  logic [N_CH-1:0]  tready,
  output logic [N_CH-1:0]  axis_block_sigs,
  output logic             block_any,
  output logic             first_vld,
  output logic [IDX_W-1:0] first_idx
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e             state_q [N_CH];
  state_e             state_d [N_CH];
  logic [CNT_W-1:0]   cnt_q   [N_CH];
  logic [CNT_W-1:0]   cnt_d   [N_CH];
  logic               first_vld_q, first_vld_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d;
  logic [N_CH-1:0]    stall;
  logic               found;

  // Sinks stall when the DUT is ready but nothing is offered; sources stall on backpressure.
  assign stall = (DIR_MASK & tready & ~tvalid) | (~DIR_MASK & tvalid & ~tready);

  always_comb begin
    first_vld_d = first_vld_q;
    first_idx_d = first_idx_q;
    found       = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!(enable && stall[i])) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            cnt_d[i]   = ONE;
            state_d[i] = (THRESHOLD == 1) ? ST_BLOCKED : ST_COUNT;
          end
          ST_COUNT: begin
            cnt_d[i] = cnt_q[i] + ONE;
            if (cnt_q[i] + ONE == THR) state_d[i] = ST_BLOCKED;
          end
          ST_BLOCKED: cnt_d[i] = THR;
          default: begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      // Ascending scan: the lowest simultaneously-entering channel claims the capture.
      if (state_d[i] == ST_BLOCKED && state_q[i] != ST_BLOCKED && !first_vld_q && !found) begin
        found       = 1'b1;
        first_vld_d = 1'b1;
        first_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      first_vld_q <= 1'b0;
      first_idx_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      first_vld_q <= first_vld_d;
      first_idx_q <= first_idx_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) axis_block_sigs[i] = (state_q[i] == ST_BLOCKED);
  end

  assign block_any = |axis_block_sigs;
  assign first_vld = first_vld_q;
  assign first_idx = first_idx_q;

endmodule
